// File: rtl/fft4_butterfly.sv
// -----------------------------------------------------------------------------
// fft4_butterfly
//   Radix-4 (4-point DFT) butterfly for real-valued input frames. A frame of
//   four signed words is captured on a valid/ready handshake. It then passes
//   through two registered adder stages, and the four complex bins are
//   streamed out one per handshake. No multipliers are used: the 4-point
//   twiddles are only +/-1 and +/-j.
//
//   Ports
//     i_clk, i_rst          clock (rising edge), async active-high reset
//     i_valid / o_ready     frame handshake; o_ready is high only in IDLE
//     i_word0..i_word3      signed N-bit samples x0..x3
//     o_valid / i_ready     bin handshake toward the next stage
//     o_re, o_im            signed OW-bit real/imag part of bin o_index
//     o_index, o_last       bin number 0..3; o_last marks bin 3
// -----------------------------------------------------------------------------
module fft4_butterfly #(
   parameter int N  = 16,
   parameter int OW = N + 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   input  logic signed [N-1:0]  i_word0,
   input  logic signed [N-1:0]  i_word1,
   input  logic signed [N-1:0]  i_word2,
   input  logic signed [N-1:0]  i_word3,
   output logic                 o_ready,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic signed [OW-1:0] o_re,
   output logic signed [OW-1:0] o_im,
   output logic [1:0]           o_index,
   output logic                 o_last
);

   typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

   state_t state_q, state_d;

   // stage 1: sums/differences of the even and odd sample pairs
   logic signed [N:0]    a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
   // stage 2: everything the four bins need (X1/X3 share b and +/-d)
   logic signed [OW-1:0] x0_q, x0_d, x2_q, x2_d, xb_q, xb_d, xd_q, xd_d;
   // output registers
   logic signed [OW-1:0] re_q, re_d, im_q, im_d;
   logic [1:0]           idx_q, idx_d;

   logic signed [N:0]    w0e, w1e, w2e, w3e;
   logic signed [OW-1:0] ae, be, ce, de;
   logic                 accept, bin_hs;

   assign w0e = {i_word0[N-1], i_word0};
   assign w1e = {i_word1[N-1], i_word1};
   assign w2e = {i_word2[N-1], i_word2};
   assign w3e = {i_word3[N-1], i_word3};

   assign ae = OW'(a_q);
   assign be = OW'(b_q);
   assign ce = OW'(c_q);
   assign de = OW'(d_q);

   assign accept = (state_q == IDLE) && i_valid;
   assign bin_hs = (state_q == OUT) && i_ready;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_valid) state_d = CALC;
         CALC:    state_d = OUT;
         OUT:     if (i_ready && idx_q == 2'd3) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      o_ready = (state_q == IDLE);
      o_valid = (state_q == OUT);
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      c_d   = c_q;
      d_d   = d_q;
      x0_d  = x0_q;
      x2_d  = x2_q;
      xb_d  = xb_q;
      xd_d  = xd_q;
      re_d  = re_q;
      im_d  = im_q;
      idx_d = idx_q;

      if (accept) begin
         a_d = w0e + w2e;
         b_d = w0e - w2e;
         c_d = w1e + w3e;
         d_d = w1e - w3e;
      end

      if (state_q == CALC) begin
         x0_d  = ae + ce;
         x2_d  = ae - ce;
         xb_d  = be;
         xd_d  = de;
         // bin 0 goes straight to the output so o_valid rises with OUT
         re_d  = ae + ce;
         im_d  = '0;
         idx_d = 2'd0;
      end

      // after the bin-3 handshake the last bin simply stays on the outputs
      if (bin_hs && idx_q != 2'd3) begin
         idx_d = idx_q + 2'd1;
         case (idx_q + 2'd1)
            2'd1:    begin re_d = xb_q; im_d = -xd_q; end
            2'd2:    begin re_d = x2_q; im_d = '0;    end
            default: begin re_d = xb_q; im_d = xd_q;  end
         endcase
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         a_q   <= '0;
         b_q   <= '0;
         c_q   <= '0;
         d_q   <= '0;
         x0_q  <= '0;
         x2_q  <= '0;
         xb_q  <= '0;
         xd_q  <= '0;
         re_q  <= '0;
         im_q  <= '0;
         idx_q <= 2'd0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         c_q   <= c_d;
         d_q   <= d_d;
         x0_q  <= x0_d;
         x2_q  <= x2_d;
         xb_q  <= xb_d;
         xd_q  <= xd_d;
         re_q  <= re_d;
         im_q  <= im_d;
         idx_q <= idx_d;
      end
   end

   assign o_re    = re_q;
   assign o_im    = im_q;
   assign o_index = idx_q;
   assign o_last  = (idx_q == 2'd3);

endmodule

// File: tb/tb_fft4_butterfly.sv
module tb_fft4_butterfly;

   localparam int N  = 16;
   localparam int OW = N + 2;

   logic                 i_clk = 1'b0;
   logic                 i_rst;
   logic                 i_valid;
   logic signed [N-1:0]  i_word0, i_word1, i_word2, i_word3;
   logic                 o_ready, o_valid, i_ready;
   logic signed [OW-1:0] o_re, o_im;
   logic [1:0]           o_index;
   logic                 o_last;

   fft4_butterfly #(.N(N), .OW(OW)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .i_word0 (i_word0),
      .i_word1 (i_word1),
      .i_word2 (i_word2),
      .i_word3 (i_word3),
      .o_ready (o_ready),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_re    (o_re),
      .o_im    (o_im),
      .o_index (o_index),
      .o_last  (o_last)
   );

   always #5 i_clk = ~i_clk;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   int acc_cyc;
   logic idle_chk = 1'b0;
   logic [2*OW+2:0] sb_q[$];

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Direct 4-point DFT: twiddle W^(n*k) is 1, -j, -1, +j for (n*k) mod 4
   function automatic logic [2*OW+2:0] exp_bin(input int x0, x1, x2, x3, input int k);
      int xs[4];
      int re, im;
      logic [OW-1:0] r, m;
      logic [1:0] kk;
      xs = '{x0, x1, x2, x3};
      re = 0;
      im = 0;
      for (int n = 0; n < 4; n++) begin
         case ((n * k) % 4)
            0: re += xs[n];
            1: im -= xs[n];
            2: re -= xs[n];
            default: im += xs[n];
         endcase
      end
      r  = re[OW-1:0];
      m  = im[OW-1:0];
      kk = k[1:0];
      return {r, m, kk, (k == 3)};
   endfunction

   // Scoreboard monitor: head of queue must be on the outputs whenever o_valid
   // (so a held bin is rechecked every stalled cycle); popped on handshake.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (idle_chk) begin
            chk("post_last_idle", 64'({o_ready, o_valid}), 64'(2'b10));
            idle_chk <= 1'b0;
         end
         if (sb_q.size() == 0) begin
            chk("no_extra_bin", 64'(o_valid), 64'(1'b0));
         end else if (o_valid) begin
            chk("bin", 64'({o_re, o_im, o_index, o_last}), 64'(sb_q[0]));
            if (i_ready) begin
               void'(sb_q.pop_front());
               if (o_last) idle_chk <= 1'b1;
            end
         end
      end
   end

   // Presents a frame, holds i_valid until the DUT is ready, returns 1ns after
   // the acceptance edge. push=0 leaves the frame off the scoreboard.
   task automatic send(input int x0, x1, x2, x3, input bit push);
      int t;
      i_word0 = x0[N-1:0];
      i_word1 = x1[N-1:0];
      i_word2 = x2[N-1:0];
      i_word3 = x3[N-1:0];
      i_valid = 1'b1;
      if (push) for (int k = 0; k < 4; k++) sb_q.push_back(exp_bin(x0, x1, x2, x3, k));
      t = 0;
      @(negedge i_clk);
      while (!o_ready && t < 50) begin
         @(negedge i_clk);
         t++;
      end
      chk("accept_wait", 64'(o_ready), 64'(1'b1));
      @(posedge i_clk);
      #1;
      acc_cyc = cyc;
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb_q.size() != 0 && t < 200) begin
         @(posedge i_clk);
         t++;
      end
      chk("drain", 64'(sb_q.size()), 64'(0));
      repeat (8) @(posedge i_clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] pat;
      int c1;
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_word0 = '0;
      i_word1 = '0;
      i_word2 = '0;
      i_word3 = '0;
      repeat (2) @(posedge i_clk);
      #1;
      chk("reset_state", 64'({o_ready, o_valid, o_re, o_im, o_index, o_last}),
          64'({1'b1, 1'b0, {OW{1'b0}}, {OW{1'b0}}, 2'd0, 1'b0}));
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;

      // basic frame and latency
      i_ready = 1'b1;
      send(1, 2, 3, 4, 1);
      @(negedge i_clk);
      chk("lat_calc", 64'({o_valid, o_ready}), 64'(2'b00));
      @(negedge i_clk);
      chk("lat_out", 64'(o_valid), 64'(1'b1));
      @(posedge i_clk);
      #1;
      drain();

      // extremes
      send(32767, 32767, 32767, 32767, 1);
      send(-32768, -32768, -32768, -32768, 1);
      send(32767, -32768, 32767, -32768, 1);
      drain();

      // backpressure 1,0,0,1,0,1,1 during OUT
      i_ready = 1'b0;
      pat = 7'b1101001;   // bit i applies in cycle i
      send(1, 2, 3, 4, 1);
      @(posedge i_clk);
      for (int i = 0; i < 7; i++) begin
         #1 i_ready = pat[i];
         @(posedge i_clk);
      end
      #1;
      chk("bp_consumed", 64'(sb_q.size()), 64'(0));
      i_ready = 1'b1;
      drain();

      // busy drop: second frame offered during CALC/OUT never appears
      send(1, 2, 3, 4, 1);
      i_valid = 1'b1;
      i_word0 = 16'sd5;
      i_word1 = 16'sd5;
      i_word2 = 16'sd5;
      i_word3 = 16'sd5;
      chk("busy_not_ready", 64'(o_ready), 64'(1'b0));
      repeat (2) @(posedge i_clk);
      #1 i_valid = 1'b0;
      drain();

      // reset in the middle of a frame, while bin 1 is presented
      i_ready = 1'b0;
      send(1, 2, 3, 4, 1);
      @(posedge i_clk);
      #1 i_ready = 1'b1;
      @(posedge i_clk);
      #1 i_ready = 1'b0;
      chk("pre_rst_index", 64'(o_index), 64'(2'd1));
      #2 i_rst = 1'b1;
      #1;
      chk("mid_rst_out", 64'({o_ready, o_valid, o_re, o_im, o_index, o_last}),
          64'({1'b1, 1'b0, {OW{1'b0}}, {OW{1'b0}}, 2'd0, 1'b0}));
      sb_q.delete();
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      i_ready = 1'b1;
      send(0, 1, 0, -1, 1);
      drain();

      // back-to-back with i_valid held: 6-cycle frame period
      send(1, 2, 3, 4, 1);
      c1 = acc_cyc;
      send(-7, 100, 3, -20, 1);
      chk("b2b_period", 64'(acc_cyc - c1), 64'(6));
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
